comp_capture: RTL and testbench
===============================

Name: comp_capture

Overview:
- Readout-side receiver for the single-bit comparator stream driven off-chip through the 16:1 comparator mux and LVDS TX.
- Sits in the FPGA/test-harness firmware behind the LVDS RX buffer.
- Synchronizes the asynchronous comparator bit and samples it on sequencer-supplied decision strobes.
- Assembles NCYC decisions (MSB first) into one conversion word, tags it with the mux channel, and hands it downstream with valid/ready.

Parameters:
- NCYC, 16, comparator decisions per conversion (word width); legal range 2..32.
- SYNC_STAGES, 2, flip-flop stages in the comp_in synchronizer; legal range 2..4.
- CHW, 4, width of the channel tag (matches the 4-bit mux select).

Ports:
- clk  input  1  capture clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- comp_in  input  1  comparator bit from LVDS RX; asynchronous to clk.
- mux_sel  input  CHW  channel currently selected on chip; quasi-static.
- conv_start  input  1  one-cycle pulse marking the start of a conversion.
- bit_strobe  input  1  one-cycle pulse; sample the synchronized comparator bit now.
- word_data  output  NCYC  assembled conversion word.
- word_chan  output  CHW  mux_sel latched at conv_start.
- word_valid  output  1  word_data and word_chan are valid.
- word_ready  input  1  downstream accepts the word.
- busy  output  1  capture in progress.
- err_abort  output  1  sticky: a conversion was aborted by a new conv_start.
- err_ovf  output  1  sticky: a completed word was dropped because the output was still full.
- clr_err  input  1  synchronous clear of both sticky flags.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, shift register 0, bit count 0, synchronizer flops 0.
- Output reset values: word_data=0, word_chan=0, word_valid=0, busy=0, err_abort=0, err_ovf=0.
- Synchronizer: comp_in passes through SYNC_STAGES flops to give comp_s. bit_strobe and conv_start are clk-domain signals and are not synchronized. The sequencer accounts for the SYNC_STAGES cycles of delay.
- FSM states: IDLE and CAPTURE. The output register is independent of the FSM.
- IDLE:
  - conv_start=1: latch mux_sel into a tag register, clear shift register and count, go to CAPTURE.
  - bit_strobe is ignored in IDLE.
- CAPTURE:
  - Each bit_strobe stores comp_s into bit (NCYC-1-count) and increments count. The first decision is the MSB.
  - On the strobe where count reaches NCYC-1, the word completes and the FSM returns to IDLE.
  - busy=1 throughout CAPTURE.
- Completion latency: word_valid rises the cycle after the final bit_strobe. word_data includes that final bit.
- conv_start while in CAPTURE: discard the partial word, set err_abort, restart capture (re-latch tag, count=0). If bit_strobe arrives in the same cycle, conv_start wins and the strobe is ignored.
- Output handshake:
  - word_valid stays high until word_valid and word_ready are both high on a rising edge.
  - word_data and word_chan stay stable while word_valid=1.
- Completion while output is full:
  - If word_valid=1 and word_ready=1 in the completion cycle, the new word is loaded and word_valid stays 1. This is back-to-back operation with no bubble.
  - If word_valid=1 and word_ready=0 in the completion cycle, the new word is dropped, the old word is kept, and err_ovf is set.
- clr_err=1 clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- rst_n asserted mid-capture or with word_valid=1: everything returns to reset values immediately, and the pending word is lost.
- No arithmetic beyond the count. The count is $clog2(NCYC+1) bits and never wraps; it is reset at each conv_start.

Decomposition:
- Shared package frida_readout_pkg holds:
  - constants NCYC_DEFAULT=16 and CHW=4;
  - typedef comp_word_t (NCYC bits);
  - typedef chan_t (CHW bits);
  - typedef cap_state_e {IDLE, CAPTURE}.
- One natural sub-module: sync_ff (parameterized N-stage async-reset synchronizer) for comp_in. It is reusable by other LVDS RX paths.

Test Plan:
- Basic capture: reset, then mux_sel=4'h5, conv_start, 16 strobes with comp_in pattern 1010_0000_1111_0001 (MSB first), word_ready=1 -> word_data=16'hA0F1, word_chan=4'h5, word_valid high for exactly 1 cycle, one cycle after the last strobe.
- Abort: conv_start, 7 strobes, then conv_start again, then 16 strobes of all 1 -> err_abort=1, single word 16'hFFFF; the partial word is never presented.
- Backpressure/overflow: word_ready=0, complete word 16'h1234, then complete 16'h5678 -> word_data remains 16'h1234, err_ovf=1. Raise word_ready -> 16'h1234 accepted once, word_valid=0. clr_err -> err_ovf=0.
- Back-to-back: complete word A; hold word_ready=1 so that word B completes in the same cycle A is accepted -> word_valid stays 1 with no bubble, B presented next, err_ovf=0.
- Stray strobes and idle: 5 bit_strobe pulses in IDLE -> no word, busy=0. Set mux_sel=4'hF, conv_start, change mux_sel to 4'h2 mid-capture -> word_chan=4'hF.
- Async reset mid-capture: assert rst_n low between strobes 8 and 9, and separately while word_valid=1 -> all outputs 0 immediately. A fresh conversion afterwards captures correctly.

Source files
------------

// File: rtl/frida_readout_pkg.sv
// frida_readout_pkg: shared types and constants for the comparator readout path
package frida_readout_pkg;
    localparam int NCYC_DEFAULT = 16;
    localparam int CHW = 4;
    typedef logic [NCYC_DEFAULT-1:0] comp_word_t;
    typedef logic [CHW-1:0] chan_t;
    typedef enum logic {IDLE, CAPTURE} cap_state_e;
endpackage

// File: rtl/sync_ff.sv
// sync_ff: N-stage async-reset synchronizer for a single asynchronous bit
module sync_ff #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [N-1:0] r;
    // shift the asynchronous bit through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= '0;
        else        r <= {r[N-2:0], d};
    end
    assign q = r[N-1];
endmodule

// File: rtl/comp_capture.sv
// comp_capture: assembles strobed comparator decisions into channel-tagged words
module comp_capture #(
    parameter int NCYC        = 16,
    parameter int SYNC_STAGES = 2,
    parameter int CHW         = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            comp_in,
    input  logic [CHW-1:0]  mux_sel,
    input  logic            conv_start,
    input  logic            bit_strobe,
    output logic [NCYC-1:0] word_data,
    output logic [CHW-1:0]  word_chan,
    output logic            word_valid,
    input  logic            word_ready,
    output logic            busy,
    output logic            err_abort,
    output logic            err_ovf,
    input  logic            clr_err
);
    import frida_readout_pkg::*;
    localparam int CW = $clog2(NCYC + 1);
    cap_state_e      state, state_nx;
    logic            comp_s;
    logic [NCYC-1:0] sh;
    logic [NCYC-1:0] word_nx;
    logic [CW-1:0]   cnt;
    logic [CHW-1:0]  tag;
    logic            take, done, abort;
    sync_ff #(.N(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (comp_in),
        .q     (comp_s)
    );
    // left shift after a clear leaves the first decision in the MSB
    assign word_nx = {sh[NCYC-2:0], comp_s};
    assign busy    = (state == CAPTURE);
    // next state; conv_start outranks a same-cycle strobe
    always_comb begin
        state_nx = state;
        take     = 1'b0;
        done     = 1'b0;
        abort    = 1'b0;
        if (state == CAPTURE) begin
            if (conv_start) begin
                abort = 1'b1;
            end else if (bit_strobe) begin
                take = 1'b1;
                if (cnt == CW'(NCYC - 1)) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
        end else if (conv_start) begin
            state_nx = CAPTURE;
        end
    end
    // capture datapath: tag latch, shift register and decision count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh    <= '0;
            cnt   <= '0;
            tag   <= '0;
        end else begin
            state <= state_nx;
            if (conv_start) begin
                tag <= mux_sel;
                sh  <= '0;
                cnt <= '0;
            end else if (take) begin
                sh  <= word_nx;
                cnt <= cnt + CW'(1);
            end
        end
    end
    // output register: load when empty or draining this cycle, else drop and flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_data  <= '0;
            word_chan  <= '0;
            word_valid <= 1'b0;
            err_abort  <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            if (done && (!word_valid || word_ready)) begin
                word_data  <= word_nx;
                word_chan  <= tag;
                word_valid <= 1'b1;
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            err_abort <= abort | (err_abort & ~clr_err);
            err_ovf   <= (done & word_valid & ~word_ready) | (err_ovf & ~clr_err);
        end
    end
endmodule

// File: tb/tb_comp_capture.sv
// tb_comp_capture: scoreboard bench for comp_capture with directed vectors
module tb_comp_capture;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        comp_in = 1'b0;
    logic [3:0]  mux_sel = '0;
    logic        conv_start = 1'b0;
    logic        bit_strobe = 1'b0;
    logic [15:0] word_data;
    logic [3:0]  word_chan;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        busy;
    logic        err_abort;
    logic        err_ovf;
    logic        clr_err = 1'b0;
    int          checks = 0;
    int          fails = 0;
    logic [19:0] sb[$];

    comp_capture dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .comp_in    (comp_in),
        .mux_sel    (mux_sel),
        .conv_start (conv_start),
        .bit_strobe (bit_strobe),
        .word_data  (word_data),
        .word_chan  (word_chan),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy),
        .err_abort  (err_abort),
        .err_ovf    (err_ovf),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [3:0] ch);
        mux_sel = ch;
        conv_start = 1'b1;
        tick();
        conv_start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        comp_in = b;
        repeat (3) tick();
        bit_strobe = 1'b1;
        tick();
        bit_strobe = 1'b0;
    endtask

    task automatic word(input logic [3:0] ch, input logic [3:0] ch2, input logic [15:0] d, input bit push);
        if (push) sb.push_back({ch, d});
        start(ch);
        for (int i = 15; i >= 0; i--) begin
            if (i == 7) mux_sel = ch2;
            send_bit(d[i]);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_data"}, 32'(word_data), 32'h0);
        chk({name, "_chan"}, 32'(word_chan), 32'h0);
        chk({name, "_flags"}, {28'h0, word_valid, busy, err_abort, err_ovf}, 32'h0);
    endtask

    // monitor: every accepted word must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_word: got %h/%h expected none", word_chan, word_data);
            end else begin
                logic [19:0] e;
                e = sb.pop_front();
                chk("mon_data", 32'(word_data), 32'(e[15:0]));
                chk("mon_chan", 32'(word_chan), 32'(e[19:16]));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [15:0] b;
        #3;
        chk_zero("reset");
        tick();
        rst_n = 1'b1;
        tick();
        // basic capture, single-cycle valid
        word_ready = 1'b1;
        word(4'h5, 4'h5, 16'hA0F1, 1'b1);
        chk("basic_valid", 32'(word_valid), 32'h1);
        chk("basic_data", 32'(word_data), 32'hA0F1);
        chk("basic_chan", 32'(word_chan), 32'h5);
        tick();
        chk("basic_valid_drop", 32'(word_valid), 32'h0);
        // abort then full capture
        start(4'h3);
        for (int i = 0; i < 7; i++) send_bit(1'b0);
        word(4'h6, 4'h6, 16'hFFFF, 1'b1);
        chk("abort_flag", 32'(err_abort), 32'h1);
        tick();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("abort_clr", 32'(err_abort), 32'h0);
        // backpressure and overflow
        word_ready = 1'b0;
        word(4'h1, 4'h1, 16'h1234, 1'b1);
        word(4'h2, 4'h2, 16'h5678, 1'b0);
        chk("ovf_data", 32'(word_data), 32'h1234);
        chk("ovf_valid", 32'(word_valid), 32'h1);
        chk("ovf_flag", 32'(err_ovf), 32'h1);
        word_ready = 1'b1;
        tick();
        chk("ovf_drain", 32'(word_valid), 32'h0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("ovf_clr", 32'(err_ovf), 32'h0);
        // back-to-back: B completes on the edge that accepts A
        word_ready = 1'b0;
        word(4'h7, 4'h7, 16'hBEEF, 1'b1);
        b = 16'hC0DE;
        sb.push_back({4'h8, b});
        start(4'h8);
        for (int i = 15; i >= 1; i--) send_bit(b[i]);
        comp_in = b[0];
        repeat (3) tick();
        bit_strobe = 1'b1;
        word_ready = 1'b1;
        tick();
        bit_strobe = 1'b0;
        chk("b2b_valid", 32'(word_valid), 32'h1);
        chk("b2b_data", 32'(word_data), 32'hC0DE);
        chk("b2b_ovf", 32'(err_ovf), 32'h0);
        tick();
        chk("b2b_drain", 32'(word_valid), 32'h0);
        // stray strobes in idle
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        chk("stray_busy", 32'(busy), 32'h0);
        chk("stray_valid", 32'(word_valid), 32'h0);
        // tag latched at start despite mux_sel change
        word(4'hF, 4'h2, 16'h5A3C, 1'b1);
        chk("tag_chan", 32'(word_chan), 32'hF);
        tick();
        // async reset mid-capture
        start(4'h9);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        chk("mid_busy", 32'(busy), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        tick();
        rst_n = 1'b1;
        tick();
        // async reset with a pending word
        word_ready = 1'b0;
        word(4'h4, 4'h4, 16'h0F0F, 1'b0);
        chk("pend_valid", 32'(word_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_zero("rst_pend");
        tick();
        rst_n = 1'b1;
        tick();
        // fresh conversion after reset
        word_ready = 1'b1;
        word(4'hC, 4'hC, 16'hC3A5, 1'b1);
        chk("fresh_data", 32'(word_data), 32'hC3A5);
        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
